// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: opcode values, default widths,
// instruction/bus field placement helpers and opcode classification.
package id_pkg;

  // Default configuration
  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 2;
  localparam int IMM_W_DEF  = 8;
  localparam int OP_W_DEF   = 4;

  // Opcode values
  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_MOVE = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_SUB  = 3;
  localparam int unsigned OP_MUL  = 4;

  // Instruction layout {imm, op, rx_idx, ry_idx}, msb..lsb
  localparam int INST_RY_LSB = 0;
  function automatic int inst_rx_lsb(input int reg_aw);
    return reg_aw;
  endfunction
  function automatic int inst_op_lsb(input int reg_aw);
    return 2 * reg_aw;
  endfunction
  function automatic int inst_imm_lsb(input int reg_aw, input int op_w);
    return 2 * reg_aw + op_w;
  endfunction

  // Bus layout {op, dest, imm, rx_val, ry_val}, msb..lsb
  localparam int BUS_RY_LSB = 0;
  function automatic int bus_rx_lsb(input int data_w);
    return data_w;
  endfunction

  // Opcodes 0..4 are defined; everything above is illegal
  function automatic logic op_is_legal(input int unsigned op);
    return op <= OP_MUL;
  endfunction

  // Legal and not a NOP: the only opcodes that are ever handed to execute
  function automatic logic op_issues(input int unsigned op);
    return (op >= OP_MOVE) && (op <= OP_MUL);
  endfunction

  function automatic logic op_uses_rx(input int unsigned op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic logic op_uses_ry(input int unsigned op);
    return op_issues(op);
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// RAW hazard detection between decode sources and the execute destination.
// Build option ID_FWD_EN: a final es_result is bypassed onto the matching
// source operand instead of stalling.
module id_hazard_unit
  import id_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [REG_AW-1:0] rx_idx,
  input  logic [REG_AW-1:0] ry_idx,
  input  logic [DATA_W-1:0] rx_value,
  input  logic [DATA_W-1:0] ry_value,
  input  logic              es_dest_valid,
  input  logic [REG_AW-1:0] es_dest,
  input  logic [DATA_W-1:0] es_result,
  input  logic              es_fwd_ok,
  output logic              stall,
  output logic [DATA_W-1:0] rx_val,
  output logic [DATA_W-1:0] ry_val
);

  logic hit_rx;
  logic hit_ry;

  // Source-use decode and destination compares
  always_comb begin
    hit_rx = op_uses_rx(32'(op)) && es_dest_valid && (rx_idx == es_dest);
    hit_ry = op_uses_ry(32'(op)) && es_dest_valid && (ry_idx == es_dest);
  end

`ifdef ID_FWD_EN
  // Bypass a final execute result; stall only while it is not yet final
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
    rx_val = rx_value;
    ry_val = ry_value;
    stall  = (hit_rx || hit_ry) && !es_fwd_ok;
    if (hit_rx && es_fwd_ok) rx_val = es_result;
    if (hit_ry && es_fwd_ok) ry_val = es_result;
  end
`else
  logic unused_fwd;

  // Without bypassing, any dependency on execute stalls decode
  always_comb begin
    rx_val     = rx_value;
    ry_val     = ry_value;
    stall      = hit_rx || hit_ry;
    unused_fwd = ^{es_result, es_fwd_ok};
  end
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage between fetch and execute: latches one instruction under a
// valid/allowin handshake, drives register-file read addresses, stalls on RAW
// hazards, squashes and flags illegal opcodes, and packs ds_to_es_bus.
// Build option ID_FWD_EN enables bypassing of es_result (see id_hazard_unit).
module id_stage_pipe
  import id_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int REG_AW = REG_AW_DEF,
  parameter  int IMM_W  = IMM_W_DEF,
  parameter  int OP_W   = OP_W_DEF,
  localparam int INST_W = IMM_W + OP_W + 2 * REG_AW,
  localparam int BUS_W  = OP_W + REG_AW + IMM_W + 2 * DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_to_ds_valid,
  input  logic [INST_W-1:0] fs_to_ds_bus,
  output logic              ds_allowin,
  output logic              ds_to_es_valid,
  output logic [BUS_W-1:0]  ds_to_es_bus,
  input  logic              es_allowin,
  output logic [REG_AW-1:0] rx,
  output logic [REG_AW-1:0] ry,
  input  logic [DATA_W-1:0] rx_value,
  input  logic [DATA_W-1:0] ry_value,
  input  logic              es_dest_valid,
  input  logic [REG_AW-1:0] es_dest,
  input  logic [DATA_W-1:0] es_result,
  input  logic              es_fwd_ok,
  input  logic              flush,
  output logic              illegal_err
);

  localparam int RX_LSB  = inst_rx_lsb(REG_AW);
  localparam int OP_LSB  = inst_op_lsb(REG_AW);
  localparam int IMM_LSB = inst_imm_lsb(REG_AW, OP_W);

  logic              ds_valid;
  logic [INST_W-1:0] inst_r;
  logic [OP_W-1:0]   op;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] rx_val;
  logic [DATA_W-1:0] ry_val;
  logic              stall;
  logic              ds_ready_go;

  assign op  = inst_r[OP_LSB +: OP_W];
  assign imm = inst_r[IMM_LSB +: IMM_W];
  assign rx  = inst_r[RX_LSB +: REG_AW];
  assign ry  = inst_r[INST_RY_LSB +: REG_AW];

  id_hazard_unit #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .OP_W   (OP_W)
  ) u_hazard (
    .op            (op),
    .rx_idx        (rx),
    .ry_idx        (ry),
    .rx_value      (rx_value),
    .ry_value      (ry_value),
    .es_dest_valid (es_dest_valid),
    .es_dest       (es_dest),
    .es_result     (es_result),
    .es_fwd_ok     (es_fwd_ok),
    .stall         (stall),
    .rx_val        (rx_val),
    .ry_val        (ry_val)
  );

  // Handshake, issue qualification and zero-when-idle output bus
  always_comb begin
    ds_ready_go    = !stall;
    ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    ds_to_es_valid = ds_valid && ds_ready_go && op_issues(32'(op));
    ds_to_es_bus   = '0;
    if (ds_to_es_valid) ds_to_es_bus = {op, rx, imm, rx_val, ry_val};
  end

  // Pipeline register: flush beats capture; hold while not allowed in
  // NOTE: the reset is asynchronous, so it appears in the sensitivity list and clears state without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state is assigned with <= so all registers update together from pre-edge values.
      ds_valid <= 1'b0;
      inst_r   <= '0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) inst_r <= fs_to_ds_bus;
    end
  end

  // Sticky illegal-opcode flag; a flushed illegal instruction still sets it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_err <= 1'b0;
    end else if (ds_valid && !op_is_legal(32'(op))) begin
      illegal_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against an
// instruction-level reference model. Build with +define+ID_FWD_EN to cover
// the bypass configuration.
module tb_id_stage_pipe;

  localparam int DATA_W = 8;
  localparam int REG_AW = 2;
  localparam int IMM_W  = 8;
  localparam int OP_W   = 4;
  localparam int INST_W = 16;
  localparam int BUS_W  = 30;
`ifdef ID_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              fs_to_ds_valid;
  logic [INST_W-1:0] fs_to_ds_bus;
  logic              ds_allowin;
  logic              ds_to_es_valid;
  logic [BUS_W-1:0]  ds_to_es_bus;
  logic              es_allowin;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;
  logic [DATA_W-1:0] rx_value;
  logic [DATA_W-1:0] ry_value;
  logic              es_dest_valid;
  logic [REG_AW-1:0] es_dest;
  logic [DATA_W-1:0] es_result;
  logic              es_fwd_ok;
  logic              flush;
  logic              illegal_err;

  id_stage_pipe #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .IMM_W  (IMM_W),
    .OP_W   (OP_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .es_allowin     (es_allowin),
    .rx             (rx),
    .ry             (ry),
    .rx_value       (rx_value),
    .ry_value       (ry_value),
    .es_dest_valid  (es_dest_valid),
    .es_dest        (es_dest),
    .es_result      (es_result),
    .es_fwd_ok      (es_fwd_ok),
    .flush          (flush),
    .illegal_err    (illegal_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: the instruction held in decode (if any) and the sticky flag
  bit        m_valid;
  bit [15:0] m_inst;
  bit        m_err;
  bit        e_allow;

  // Settle, derive expectations from the model and current inputs, compare
  task automatic sample();
    int unsigned op, rxi, ryi, imm, rv, yv;
    bit use_x, use_y, hx, hy, stl, ev;
    logic [31:0] eb;
    #3;
    if (reset) begin
      m_valid = 1'b0; m_inst = '0; m_err = 1'b0;
    end
    op  = (m_inst >> 4) & 15;
    rxi = (m_inst >> 2) & 3;
    ryi = m_inst & 3;
    imm = m_inst >> 8;
    use_x = (op >= 2) && (op <= 4);
    use_y = (op >= 1) && (op <= 4);
    hx  = use_x && es_dest_valid && (rxi == es_dest);
    hy  = use_y && es_dest_valid && (ryi == es_dest);
    stl = (hx || hy) && !(FWD && es_fwd_ok);
    e_allow = !m_valid || (!stl && es_allowin);
    ev  = m_valid && !stl && (op >= 1) && (op <= 4);
    rv  = (FWD && hx && es_fwd_ok) ? es_result : rx_value;
    yv  = (FWD && hy && es_fwd_ok) ? es_result : ry_value;
    eb  = ev ? ((op << 26) | (rxi << 24) | (imm << 16) | (rv << 8) | yv) : 0;
    check("allowin", 32'(ds_allowin), 32'(e_allow));
    check("es_valid", 32'(ds_to_es_valid), 32'(ev));
    check("bus", 32'(ds_to_es_bus), eb);
    check("rx", 32'(rx), rxi);
    check("ry", 32'(ry), ryi);
    check("illegal_err", 32'(illegal_err), 32'(m_err));
  endtask

  // Advance the model across one clock edge using the pre-edge inputs
  task automatic advance();
    bit n_valid, n_err;
    bit [15:0] n_inst;
    n_valid = m_valid; n_inst = m_inst; n_err = m_err;
    if (reset) begin
      n_valid = 1'b0; n_inst = '0; n_err = 1'b0;
    end else begin
      if (m_valid && ((m_inst >> 4) & 15) >= 5) n_err = 1'b1;
      if (flush) n_valid = 1'b0;
      else if (e_allow) begin
        n_valid = fs_to_ds_valid;
        if (fs_to_ds_valid) n_inst = fs_to_ds_bus;
      end
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_inst = n_inst; m_err = n_err;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic quiet();
    reset = 0; fs_to_ds_valid = 0; fs_to_ds_bus = '0; es_allowin = 1;
    rx_value = '0; ry_value = '0; es_dest_valid = 0; es_dest = '0;
    es_result = '0; es_fwd_ok = 0; flush = 0;
  endtask

  initial begin
    quiet();
    reset = 1;
    #1;
    tick();
    reset = 0;
    tick();

    // MOVE issues one cycle after capture with both operands on the bus
    fs_to_ds_valid = 1; fs_to_ds_bus = 16'h1216;
    tick();
    fs_to_ds_valid = 0; rx_value = 8'hAA; ry_value = 8'h55;
    sample();
    check("t2_valid", 32'(ds_to_es_valid), 32'd1);
    check("t2_rx", 32'(rx), 32'd1);
    check("t2_ry", 32'(ry), 32'd2);
    check("t2_bus", 32'(ds_to_es_bus), 32'h0512AA55);
    advance();

    // ADD depending on es_dest=3 with no final result: stall, then issue once
    fs_to_ds_valid = 1; fs_to_ds_bus = 16'h0023;
    tick();
    fs_to_ds_valid = 0; es_dest_valid = 1; es_dest = 2'd3; es_fwd_ok = 0;
    repeat (3) begin
      sample();
      check("t3_stall_allowin", 32'(ds_allowin), 32'd0);
      check("t3_stall_valid", 32'(ds_to_es_valid), 32'd0);
      advance();
    end
    es_dest_valid = 0;
    sample();
    check("t3_issue", 32'(ds_to_es_valid), 32'd1);
    advance();
    sample();
    check("t3_once", 32'(ds_to_es_valid), 32'd0);
    advance();

    // Same dependency with a final result available
    fs_to_ds_valid = 1; fs_to_ds_bus = 16'h0023;
    tick();
    fs_to_ds_valid = 0; es_dest_valid = 1; es_dest = 2'd3; es_fwd_ok = 1;
    es_result = 8'h7E; ry_value = 8'h11;
    sample();
`ifdef ID_FWD_EN
    check("t4_fwd_valid", 32'(ds_to_es_valid), 32'd1);
    check("t4_fwd_ry", 32'(ds_to_es_bus[7:0]), 32'h7E);
`else
    check("t4_nofwd_stall", 32'(ds_to_es_valid), 32'd0);
`endif
    advance();
    quiet();
    tick();
    tick();

    // Illegal opcode: bubble, sticky flag, following MUL unaffected
    fs_to_ds_valid = 1; fs_to_ds_bus = 16'h00F0;
    tick();
    fs_to_ds_bus = 16'h3A4B;
    sample();
    check("t5_illegal_valid", 32'(ds_to_es_valid), 32'd0);
    check("t5_err_early", 32'(illegal_err), 32'd0);
    advance();
    fs_to_ds_valid = 0;
    sample();
    check("t5_err", 32'(illegal_err), 32'd1);
    check("t5_mul_valid", 32'(ds_to_es_valid), 32'd1);
    advance();
    tick();

    // SUB held by execute back-pressure, then flushed while fetch offers MOVE
    fs_to_ds_valid = 1; fs_to_ds_bus = 16'h0536;
    tick();
    fs_to_ds_valid = 0; es_allowin = 0; rx_value = 8'h3C; ry_value = 8'hC3;
    repeat (3) begin
      sample();
      check("t6_hold_allowin", 32'(ds_allowin), 32'd0);
      advance();
    end
    flush = 1; fs_to_ds_valid = 1; fs_to_ds_bus = 16'h0010;
    tick();
    quiet();
    sample();
    check("t6_flushed", 32'(ds_to_es_valid), 32'd0);
    check("t6_allowin", 32'(ds_allowin), 32'd1);
    advance();

    // Reset asserted while stalled clears everything, including the flag
    fs_to_ds_valid = 1; fs_to_ds_bus = 16'h0023;
    tick();
    fs_to_ds_valid = 0; es_dest_valid = 1; es_dest = 2'd3;
    tick();
    reset = 1;
    sample();
    check("t1_allowin", 32'(ds_allowin), 32'd1);
    check("t1_err", 32'(illegal_err), 32'd0);
    check("t1_bus", 32'(ds_to_es_bus), 32'd0);
    advance();
    quiet();
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned opr;
      opr = $urandom_range(0, 9);
      reset          = ($urandom_range(0, 49) == 0);
      flush          = ($urandom_range(0, 11) == 0);
      fs_to_ds_valid = ($urandom_range(0, 3) != 0);
      fs_to_ds_bus   = {8'($urandom), (opr < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15)),
                        2'($urandom), 2'($urandom)};
      es_allowin     = ($urandom_range(0, 3) != 0);
      es_dest_valid  = 1'($urandom);
      es_dest        = 2'($urandom);
      es_result      = 8'($urandom);
      es_fwd_ok      = 1'($urandom);
      rx_value       = 8'($urandom);
      ry_value       = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
